// File: rtl/pe_pkg.sv
// Shared PE definitions: packet type codes, width derivations and config payload
// field layout used by the activation-function stage.
package pe_pkg;

  localparam logic [2:0] PKT_DATA       = 3'b000;
  localparam logic [2:0] PKT_CONF_INB   = 3'b001;
  localparam logic [2:0] PKT_CONF_W     = 3'b010;
  localparam logic [2:0] PKT_CONF_AFLUT = 3'b100;
  localparam logic [2:0] PKT_CONF_AFLB  = 3'b101;
  localparam logic [2:0] PKT_CONF_AFUB  = 3'b110;

  // CONF_AFLUT payload: {lut address, lut value}
  localparam int LUT_ADDR_LSB = 16;
  localparam int LUT_VAL_W    = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int num_w(input int network_size);
    return clog2(network_size);
  endfunction

  function automatic int seq_width(input int network_size);
    return clog2(isqrt(network_size) * 2);
  endfunction

  function automatic int sum_width(input int network_size, input int payload_width);
    return num_w(network_size) + payload_width;
  endfunction

endpackage

// File: rtl/af_lut_ram.sv
// Activation LUT storage: one write port, one registered read port with a
// synchronous output reset so the read register maps onto a block RAM.
module af_lut_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/activation_function.sv
// Activation stage: clamps each DATA sum against programmable bounds, maps it
// through a programmable LUT and emits a sign-extended neuron output.
module activation_function import pe_pkg::*; #(
  parameter int NETWORK_SIZE  = 256,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int LUT_DEPTH     = 1024,
  parameter int LUT_SHIFT     = 4,
  localparam int NUM_W     = num_w(NETWORK_SIZE),
  localparam int SEQ_WIDTH = seq_width(NETWORK_SIZE),
  localparam int SUM_WIDTH = sum_width(NETWORK_SIZE, PAYLOAD_WIDTH),
  localparam int LUT_AW    = clog2(LUT_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ACC_AF_valid,
  input  logic [2:0]               ACC_AF_type,
  input  logic [SEQ_WIDTH-1:0]     ACC_AF_seqNum,
  input  logic [SUM_WIDTH-1:0]     ACC_AF_data,
  output logic                     ACC_AF_halt,
  input  logic                     AF_OUT_halt,
  output logic                     AF_OUT_valid,
  output logic [SEQ_WIDTH-1:0]     AF_OUT_seqNum,
  output logic [PAYLOAD_WIDTH-1:0] AF_OUT_data
);

  logic                 advance;
  logic                 s1_valid;
  logic [2:0]           s1_type;
  logic [SEQ_WIDTH-1:0] s1_seq;
  logic [SUM_WIDTH-1:0] s1_data;

  logic signed [PAYLOAD_WIDTH-1:0] lb, ub;
  logic signed [SUM_WIDTH-1:0]     sum, lb_x, ub_x;
  logic signed [SUM_WIDTH:0]       diff, shifted;
  logic [LUT_AW-1:0]               idx;
  logic                            lut_we;
  logic [LUT_VAL_W-1:0]            lut_q;

  assign ACC_AF_halt = AF_OUT_valid & AF_OUT_halt;
  assign advance     = !ACC_AF_halt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_type  <= PKT_DATA;
      s1_seq   <= '0;
      s1_data  <= '0;
    end else if (advance) begin
      s1_valid <= ACC_AF_valid;
      s1_type  <= ACC_AF_type;
      s1_seq   <= ACC_AF_seqNum;
      s1_data  <= ACC_AF_data;
    end
  end

  // Bounds update at the edge that retires the config packet, so the packet
  // right behind it in S1 already indexes with the new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      lb <= '0;
      ub <= {1'b0, {(PAYLOAD_WIDTH-1){1'b1}}};
    end else if (advance && s1_valid) begin
      if (s1_type == PKT_CONF_AFLB) lb <= s1_data[PAYLOAD_WIDTH-1:0];
      if (s1_type == PKT_CONF_AFUB) ub <= s1_data[PAYLOAD_WIDTH-1:0];
    end
  end

  assign sum     = s1_data;
  assign lb_x    = {{(SUM_WIDTH-PAYLOAD_WIDTH){lb[PAYLOAD_WIDTH-1]}}, lb};
  assign ub_x    = {{(SUM_WIDTH-PAYLOAD_WIDTH){ub[PAYLOAD_WIDTH-1]}}, ub};
  assign diff    = {sum[SUM_WIDTH-1], sum} - {lb_x[SUM_WIDTH-1], lb_x};
  assign shifted = diff >>> LUT_SHIFT;

  always_comb begin
    idx = '0;
    if (sum <= lb_x)
      idx = '0;
    else if (sum >= ub_x)
      idx = LUT_AW'(LUT_DEPTH - 1);
    else if (shifted > (SUM_WIDTH+1)'(LUT_DEPTH - 1))
      idx = LUT_AW'(LUT_DEPTH - 1);
    else
      idx = shifted[LUT_AW-1:0];
  end

  assign lut_we = !rst && advance && s1_valid && (s1_type == PKT_CONF_AFLUT);

  af_lut_ram #(
    .DEPTH (LUT_DEPTH),
    .AW    (LUT_AW),
    .DW    (LUT_VAL_W)
  ) u_lut (
    .clk   (clk),
    .rst   (rst),
    .we    (lut_we),
    .waddr (s1_data[LUT_ADDR_LSB +: LUT_AW]),
    .wdata (s1_data[LUT_VAL_W-1:0]),
    .re    (advance),
    .raddr (idx),
    .rdata (lut_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      AF_OUT_valid  <= 1'b0;
      AF_OUT_seqNum <= '0;
    end else if (advance) begin
      AF_OUT_valid  <= s1_valid && (s1_type == PKT_DATA);
      AF_OUT_seqNum <= s1_seq;
    end
  end

  assign AF_OUT_data = {{(PAYLOAD_WIDTH-LUT_VAL_W){lut_q[LUT_VAL_W-1]}}, lut_q};

endmodule

// File: doc/activation_function.md
Name: activation_function

Overview:
- Stage directly downstream of the PE accumulator: consumes its valid/type/seqNum/data stream and produces one neuron output per completed weighted sum.
- DATA sums are clamped against programmable lower/upper bounds, then mapped through a programmable lookup table (LUT) to a signed 16-bit value.
- Config packets CONF_AFLB, CONF_AFUB and CONF_AFLUT program the block and are consumed here. All other packet types are dropped.
- Output feeds the PE output packetizer.

Parameters:
- NETWORK_SIZE, 256, number of neurons; sets NUM_W=$clog2(NETWORK_SIZE) and SEQ_WIDTH=$clog2($sqrt(NETWORK_SIZE)*2) (=5).
- PAYLOAD_WIDTH, 32, payload width; SUM_WIDTH=NUM_W+PAYLOAD_WIDTH (=40).
- LUT_DEPTH, 1024, number of LUT entries; LUT_AW=$clog2(LUT_DEPTH).
- LUT_SHIFT, 4, right shift applied to (sum-lb) to form the LUT index.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- ACC_AF_valid  input  1  upstream packet valid
- ACC_AF_type  input  3  packet type
- ACC_AF_seqNum  input  SEQ_WIDTH  sequence number
- ACC_AF_data  input  SUM_WIDTH  DATA: signed sum; config: {inputNum[NUM_W], payload[PAYLOAD_WIDTH]}
- ACC_AF_halt  output  1  backpressure to the accumulator
- AF_OUT_halt  input  1  backpressure from the packetizer
- AF_OUT_valid  output  1  neuron output valid
- AF_OUT_seqNum  output  SEQ_WIDTH  sequence number of the DATA packet
- AF_OUT_data  output  PAYLOAD_WIDTH  LUT value sign-extended from 16 bits

Behaviour:
- Type codes: DATA=3'b000, CONF_INB=3'b001, CONF_W=3'b010, CONF_AFLUT=3'b100, CONF_AFLB=3'b101, CONF_AFUB=3'b110.
- advance = !(AF_OUT_valid & AF_OUT_halt). ACC_AF_halt = AF_OUT_valid & AF_OUT_halt. When advance=0, all stage registers and config registers hold.
- Stage S1 (input register): on an edge with advance=1, captures valid, type, seqNum and data from the ACC_AF_* inputs.
- Config actions are taken from S1 on an edge with advance=1 and s1_valid=1:
  - CONF_AFLB: lb <= payload (signed).
  - CONF_AFUB: ub <= payload (signed).
  - CONF_AFLUT: lut[payload[PAYLOAD_WIDTH-1:16][LUT_AW-1:0]] <= payload[15:0].
  - Any other non-DATA type: discarded, no output.
- Index computation (combinational from S1; lb and ub sign-extended to SUM_WIDTH):
  - sum <= lb: idx=0.
  - sum >= ub: idx=LUT_DEPTH-1.
  - otherwise: idx=min((sum-lb)>>>LUT_SHIFT, LUT_DEPTH-1).
  - Subtraction is performed at SUM_WIDTH+1 bits, so it never overflows.
- Stage S2 (output register): synchronous LUT read. On an edge with advance=1:
  - AF_OUT_valid <= s1_valid & (s1_type==DATA).
  - AF_OUT_seqNum <= s1_seqNum.
  - AF_OUT_data <= sign-extended lut[idx].
- Latency: a DATA packet accepted on edge N is presented on AF_OUT at edge N+1 (one register stage after S1). Throughput is one packet per cycle when not halted.
- Write/read ordering: a LUT, lb or ub write committed on edge N is visible to the DATA packet sitting in S1 during cycle N+1, i.e. the packet immediately behind the config packet. No stale read is permitted.
- Outputs hold stable while AF_OUT_valid & AF_OUT_halt. No packet is lost or duplicated; packet order is preserved.
- Reset (synchronous, overrides everything, including mid-stream):
  - AF_OUT_valid=0, AF_OUT_seqNum=0, AF_OUT_data=0, ACC_AF_halt=0.
  - s1_valid=0.
  - lb=0, ub=max positive PAYLOAD_WIDTH value.
  - In-flight packets are dropped.
  - LUT contents are not reset (RAM); they are undefined until written.
- Simultaneous upstream valid and downstream halt: the input is not captured; the upstream holds its packet because ACC_AF_halt=1.

Decomposition:
- Shared package pe_pkg holds:
  - the type-code constants;
  - the NUM_W, SEQ_WIDTH and SUM_WIDTH derivation functions;
  - the config-payload field offsets (LUT address at [31:16], LUT value at [15:0]).
- One sub-module, af_lut_ram: single-port write, single synchronous read, LUT_DEPTH x 16, inferable as BRAM.

Test Plan:
- Reset: assert rst 3 cycles with ACC_AF_valid=1 -> AF_OUT_valid=0, ACC_AF_halt=0, AF_OUT_data=0 throughout.
- Mapping: program lb=-512 (0xFFFFFE00), ub=512, lut[k]=k for all k; send DATA sum=0, seq=7 -> one edge after acceptance, AF_OUT_valid=1, data=32, seqNum=7.
- Clamp: send DATA sums 600, 512, -1000, -512 back-to-back -> outputs 1023, 1023, 0, 0 on consecutive cycles.
- Backpressure: send 3 DATA packets (sums 0, 16, 32); hold AF_OUT_halt for 5 cycles from the first output -> ACC_AF_halt=1 during the stall; output 32 is held stable, then 32, 33, 34 appear in order with none lost.
- Write ordering: CONF_AFLUT addr 32, value 0x8000, followed immediately by DATA sum=0 -> output 0xFFFF8000. CONF_W and CONF_INB packets interleaved in the stream produce no output.
- Mid-stream reset: rst pulsed while 2 packets are in flight -> no output afterwards; lb/ub return to reset values (a following DATA sum=0 reads lut[0]).
